// File: rtl/crc_fcs_checker_if.sv
// Packet-level bus between the CRC generator side and the FCS checker.
// Handshake: an FCS word transfers on a rising clk edge where fcs_vld && fcs_rdy.
// fcs_vld may rise independently of fcs_rdy; the source holds fcs_in stable
// until the transfer completes. crc_in_vld is a one-cycle strobe with no
// backpressure. res_vld is a one-cycle strobe; res_ok/res_crc/res_fcs hold
// their values until the next strobe.
interface crc_fcs_checker_if #(
  parameter int CRC_WIDTH = 32
) ();
  logic [CRC_WIDTH-1:0] fcs_in;
  logic                 fcs_vld;
  logic                 fcs_rdy;
  logic [CRC_WIDTH-1:0] crc_in;
  logic                 crc_in_vld;
  logic                 res_vld;
  logic                 res_ok;
  logic [CRC_WIDTH-1:0] res_crc;
  logic [CRC_WIDTH-1:0] res_fcs;

  modport master (
    output fcs_in, fcs_vld, crc_in, crc_in_vld,
    input  fcs_rdy, res_vld, res_ok, res_crc, res_fcs
  );

  modport slave (
    input  fcs_in, fcs_vld, crc_in, crc_in_vld,
    output fcs_rdy, res_vld, res_ok, res_crc, res_fcs
  );
endinterface

// File: rtl/crc_fcs_checker.sv
// Compares the computed CRC of each packet with the expected FCS taken from
// the packet trailer. Expected FCS values wait in a small FIFO so that the
// generator's pipeline latency is absorbed; results come out in push order
// one cycle after each CRC strobe, along with saturating statistics.
module crc_fcs_checker #(
  parameter int CRC_WIDTH  = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_cnt,
  crc_fcs_checker_if.slave     bus,
  output logic [CNT_WIDTH-1:0] pkt_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic                 orphan_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0]        OCC_FULL = OW'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [CRC_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [OW-1:0]        occ;
  logic [OW-1:0]        occ_next;
  logic                 rdy_q;
  logic                 push;
  logic                 pop;
  logic                 empty;
  logic                 orphan_hit;
  logic [CRC_WIDTH-1:0] head;
  logic                 match;

  // Emptiness comes from registered occupancy, so an FCS pushed this cycle
  // is not visible to a same-cycle CRC strobe (no bypass path).
  assign empty      = (occ == '0);
  assign push       = bus.fcs_vld && rdy_q;
  assign pop        = bus.crc_in_vld && !empty;
  assign orphan_hit = bus.crc_in_vld && empty;
  assign head       = mem[rd_ptr];
  assign match      = (bus.crc_in == head);
  assign bus.fcs_rdy = rdy_q;

  // Occupancy after this cycle's push/pop.
  always_comb begin
    occ_next = occ;
    case ({push, pop})
      2'b10:   occ_next = occ + OW'(1);
      2'b01:   occ_next = occ - OW'(1);
      default: occ_next = occ;
    endcase
  end

  // FIFO storage; contents are meaningless until pointed at, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.fcs_in;
  end

  // FIFO pointers, occupancy and the registered not-full flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
      rdy_q  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      occ   <= occ_next;
      rdy_q <= (occ_next != OCC_FULL);
    end
  end

  // Result strobe and held result fields, one cycle after each pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.res_vld <= 1'b0;
      bus.res_ok  <= 1'b0;
      bus.res_crc <= '0;
      bus.res_fcs <= '0;
    end else begin
      bus.res_vld <= pop;
      if (pop) begin
        bus.res_ok  <= match;
        bus.res_crc <= bus.crc_in;
        bus.res_fcs <= head;
      end
    end
  end

  // Saturating statistics and sticky orphan flag; clear beats any update.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_cnt    <= '0;
      err_cnt    <= '0;
      orphan_err <= 1'b0;
    end else if (clr_cnt) begin
      pkt_cnt    <= '0;
      err_cnt    <= '0;
      orphan_err <= 1'b0;
    end else begin
      if (pop && (pkt_cnt != CNT_MAX)) pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
      if (pop && !match && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_WIDTH'(1);
      if (orphan_hit) orphan_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_crc_fcs_checker.sv
// Bench for crc_fcs_checker: stimulus tasks feed a queue-based reference
// model; a monitor compares per-cycle status and every result strobe.
module tb_crc_fcs_checker;
  localparam int CW    = 32;
  localparam int DEPTH = 16;
  localparam int NW    = 6;
  localparam int CMAX  = (1 << NW) - 1;
  localparam int SW    = 3 + 2 * NW;
  localparam int RW    = 1 + 2 * CW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr_cnt = 1'b0;
  logic [NW-1:0] pkt_cnt;
  logic [NW-1:0] err_cnt;
  logic          orphan_err;

  crc_fcs_checker_if #(.CRC_WIDTH(CW)) bus ();

  crc_fcs_checker #(
    .CRC_WIDTH (CW),
    .FIFO_DEPTH(DEPTH),
    .CNT_WIDTH (NW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr_cnt   (clr_cnt),
    .bus       (bus),
    .pkt_cnt   (pkt_cnt),
    .err_cnt   (err_cnt),
    .orphan_err(orphan_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [CW-1:0] mq[$];
  int            m_pkt = 0;
  int            m_err = 0;
  logic          m_orph = 1'b0;

  // scoreboard queues: per-cycle status and per-result expectations
  logic [SW-1:0] st_q[$];
  logic [RW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus, entered and left at posedge+2.
  task automatic step(input logic fv, input logic [CW-1:0] f, input logic cv,
                      input logic [CW-1:0] c, input logic clr);
    logic          rdy;
    logic          push;
    logic          pop;
    logic [CW-1:0] hd;
    bus.fcs_vld    = fv;
    bus.fcs_in     = f;
    bus.crc_in_vld = cv;
    bus.crc_in     = c;
    clr_cnt        = clr;
    rdy  = (mq.size() < DEPTH);
    push = fv && rdy;
    pop  = cv && (mq.size() > 0);
    if (pop) begin
      hd = mq.pop_front();
      exp_q.push_back({(c == hd), c, hd});
      m_pkt = (m_pkt + 1 > CMAX) ? CMAX : m_pkt + 1;
      if (c != hd) m_err = (m_err + 1 > CMAX) ? CMAX : m_err + 1;
    end else if (cv) begin
      m_orph = 1'b1;
    end
    if (push) mq.push_back(f);
    if (clr) begin
      m_pkt  = 0;
      m_err  = 0;
      m_orph = 1'b0;
    end
    st_q.push_back({pop, (mq.size() < DEPTH), m_orph, NW'(m_pkt), NW'(m_err)});
    @(posedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.fcs_vld = 1'b0; bus.fcs_in = '0; bus.crc_in_vld = 1'b0; bus.crc_in = '0;
    clr_cnt = 1'b0;
    mq.delete(); st_q.delete(); exp_q.delete();
    m_pkt = 0; m_err = 0; m_orph = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_res_vld", 64'(bus.res_vld), 64'd0);
    chk("rst_res_ok", 64'(bus.res_ok), 64'd0);
    chk("rst_res_crc", 64'(bus.res_crc), 64'd0);
    chk("rst_res_fcs", 64'(bus.res_fcs), 64'd0);
    chk("rst_pkt_cnt", 64'(pkt_cnt), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_orphan", 64'(orphan_err), 64'd0);
    chk("rst_fcs_rdy", 64'(bus.fcs_rdy), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
  endtask

  // monitor: samples 1 time unit after each active edge
  logic [SW-1:0] mon_s;
  logic [RW-1:0] mon_r;
  always @(posedge clk) begin
    #1;
    if (rst && st_q.size() > 0) begin
      mon_s = st_q.pop_front();
      chk("res_vld", 64'(bus.res_vld), 64'(mon_s[SW-1]));
      chk("fcs_rdy", 64'(bus.fcs_rdy), 64'(mon_s[SW-2]));
      chk("orphan_err", 64'(orphan_err), 64'(mon_s[SW-3]));
      chk("pkt_cnt", 64'(pkt_cnt), 64'(mon_s[2*NW-1:NW]));
      chk("err_cnt", 64'(err_cnt), 64'(mon_s[NW-1:0]));
      if (bus.res_vld) begin
        if (exp_q.size() == 0) begin
          chk("res_unexpected", 64'd1, 64'd0);
        end else begin
          mon_r = exp_q.pop_front();
          chk("res_ok", 64'(bus.res_ok), 64'(mon_r[RW-1]));
          chk("res_crc", 64'(bus.res_crc), 64'(mon_r[2*CW-1:CW]));
          chk("res_fcs", 64'(bus.res_fcs), 64'(mon_r[CW-1:0]));
        end
      end
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench did not finish");
  end

  logic [CW-1:0] rc;
  initial begin
    do_reset();

    // matching CRC after a short generator latency
    step(1'b1, 32'hCBF43926, 1'b0, '0, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b1, 32'hCBF43926, 1'b0);
    idle(2);

    // mismatching CRC
    step(1'b1, 32'h11111111, 1'b0, '0, 1'b0);
    idle(1);
    step(1'b0, '0, 1'b1, 32'h11111112, 1'b0);
    idle(2);

    // fill the FIFO, offer one more, then drain in order
    for (int i = 0; i < DEPTH; i++) step(1'b1, $urandom, 1'b0, '0, 1'b0);
    step(1'b1, 32'hDEADBEEF, 1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1, mq[0], 1'b0);
    for (int i = 0; i < DEPTH - 1; i++) begin
      rc = ($urandom_range(0, 1) == 1) ? mq[0] : $urandom;
      step(1'b0, '0, 1'b1, rc, 1'b0);
    end
    idle(2);

    // orphan strobe, then clear
    step(1'b0, '0, 1'b1, 32'h12345678, 1'b0);
    idle(1);
    step(1'b0, '0, 1'b0, '0, 1'b1);
    idle(1);

    // push into empty FIFO with same-cycle strobe is an orphan; clear wins over set
    step(1'b1, 32'hA5A5A5A5, 1'b1, 32'hA5A5A5A5, 1'b0);
    step(1'b0, '0, 1'b1, 32'hA5A5A5A5, 1'b1);
    idle(1);
    step(1'b0, '0, 1'b0, '0, 1'b1);

    // counter saturation: many mostly-mismatching results
    for (int i = 0; i < CMAX + 12; i++) step(1'b1, $urandom, 1'b1, $urandom, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b0, '0, 1'b1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      rc = ((mq.size() > 0) && ($urandom_range(0, 2) != 0)) ? mq[0] : $urandom;
      step(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 4) < 2), rc,
           ($urandom_range(0, 50) == 0));
    end
    idle(2);

    // reset with FCS queued: contents discarded, next strobe is an orphan
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0, '0, 1'b0);
    do_reset();
    step(1'b0, '0, 1'b1, 32'h0BADF00D, 1'b0);
    idle(3);

    chk("results_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
